// File: rtl/output_fifo_writeback.sv
// Streams line_num 512-bit lines from the output buffer into the DDR write FIFO via a credit-limited skid FIFO.
// First push RD_LATENCY+1 cycles after the first read, then one line per cycle; ddr_fifo_full stalls pushes and reads stop once credits run out.
module output_fifo_writeback #(
    parameter int DDR_ADDR_LEN = 32,
    parameter int ADDR_LEN     = 16,
    parameter int DATA_LEN     = 64,
    parameter int SINGLE_LEN   = 24,
    parameter int RD_LATENCY   = 2,
    parameter int SKID_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    conf,
    input  logic [SINGLE_LEN-1:0]   line_num,
    input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr,
    input  logic [ADDR_LEN-1:0]     ob_st_addr,
    output logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
    output logic [SINGLE_LEN-1:0]   ddr_len,
    output logic                    ddr_conf,
    output logic [ADDR_LEN-1:0]     ob_addr,
    output logic                    ob_en,
    input  logic [DATA_LEN*8-1:0]   ob_data,
    input  logic                    ddr_fifo_full,
    output logic                    ddr_fifo_wr,
    output logic [DATA_LEN*8-1:0]   ddr_fifo_data,
    output logic                    idle
);

    localparam int LW = DATA_LEN * 8;
    localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW = $clog2(SKID_DEPTH + 1) + 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(SKID_DEPTH);
    localparam logic [PW-1:0] PTR_MAX = PW'(SKID_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [SINGLE_LEN-1:0]   line_num_q, line_num_d;
    logic [SINGLE_LEN-1:0]   issued_q, issued_d;
    logic [SINGLE_LEN-1:0]   pushed_q, pushed_d;
    logic [ADDR_LEN-1:0]     ob_addr_q, ob_addr_d;
    logic [DDR_ADDR_LEN-1:0] ddr_addr_q, ddr_addr_d;
    logic [SINGLE_LEN-1:0]   ddr_len_q, ddr_len_d;
    logic                    ddr_conf_q, ddr_conf_d;
    logic [RD_LATENCY-1:0]   vld_q, vld_d;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]           mem_q [SKID_DEPTH];

    logic accept, credit_ok, skid_wr, skid_empty, push, last_issue, last_push;

    assign accept     = conf && (state_q == S_IDLE) && (line_num != '0);
    // Reads in flight plus lines already parked must leave room for one more read.
    assign credit_ok  = (({1'b0, inflight_q} + {1'b0, cnt_q}) < DEPTH_C);
    assign skid_wr    = vld_q[RD_LATENCY-1];
    assign skid_empty = (cnt_q == '0);
    assign push       = !skid_empty && !ddr_fifo_full;
    assign last_issue = ob_en && (issued_q == line_num_q - SINGLE_LEN'(1));
    assign last_push  = push && (pushed_q == line_num_q - SINGLE_LEN'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept)     state_d = S_ISSUE;
            S_ISSUE: if (last_issue) state_d = S_DRAIN;
            S_DRAIN: if (last_push)  state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ob_en = 1'b0;
        idle  = 1'b0;
        case (state_q)
            S_IDLE:  idle  = 1'b1;
            S_ISSUE: ob_en = !ddr_conf_q && (issued_q < line_num_q) && credit_ok;
            default: ;
        endcase
    end

    always_comb begin
        line_num_d = line_num_q;
        issued_d   = issued_q;
        pushed_d   = pushed_q;
        ob_addr_d  = ob_addr_q;
        ddr_addr_d = ddr_addr_q;
        ddr_len_d  = ddr_len_q;
        ddr_conf_d = accept;
        if (accept) begin
            line_num_d = line_num;
            issued_d   = '0;
            pushed_d   = '0;
            ob_addr_d  = ob_st_addr;
            ddr_addr_d = ddr_st_addr;
            ddr_len_d  = line_num << 6;
        end
        if (ob_en) begin
            issued_d  = issued_q + SINGLE_LEN'(1);
            ob_addr_d = ob_addr_q + ADDR_LEN'(1);
        end
        if (push) begin
            pushed_d = pushed_q + SINGLE_LEN'(1);
        end
    end

    always_comb begin
        vld_d[0] = ob_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
        end
        inflight_d = inflight_q + CW'(ob_en) - CW'(skid_wr);
        cnt_d      = cnt_q + CW'(skid_wr) - CW'(push);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (skid_wr) begin
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
        end
        if (push) begin
            rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_num_q <= '0;
            issued_q   <= '0;
            pushed_q   <= '0;
            ob_addr_q  <= '0;
            ddr_addr_q <= '0;
            ddr_len_q  <= '0;
            ddr_conf_q <= 1'b0;
            vld_q      <= '0;
            inflight_q <= '0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            line_num_q <= line_num_d;
            issued_q   <= issued_d;
            pushed_q   <= pushed_d;
            ob_addr_q  <= ob_addr_d;
            ddr_addr_q <= ddr_addr_d;
            ddr_len_q  <= ddr_len_d;
            ddr_conf_q <= ddr_conf_d;
            vld_q      <= vld_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked whenever the skid is empty.
    always_ff @(posedge clk) begin
        if (skid_wr) begin
            mem_q[wr_ptr_q] <= ob_data;
        end
    end

    assign ddr_st_addr_out = ddr_addr_q;
    assign ddr_len         = ddr_len_q;
    assign ddr_conf        = ddr_conf_q;
    assign ob_addr         = ob_addr_q;
    assign ddr_fifo_wr     = push;
    assign ddr_fifo_data   = skid_empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: doc/output_fifo_writeback.md
OUTPUT_FIFO_WRITEBACK -- requirements
Module: output_fifo_writeback

Interface
REQ-001 SHALL have parameters: DDR_ADDR_LEN, default 32, DDR byte-address width; ADDR_LEN, default 16, output-buffer word-address width; DATA_LEN, default 64, bank width; SINGLE_LEN, default 24, length-field width; RD_LATENCY, default 2, buffer read latency in cycles; SKID_DEPTH, default 4, local line FIFO depth.
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 conf  input  1  one-cycle start pulse; samples the configuration inputs.
REQ-005 line_num  input  SINGLE_LEN  number of 512-bit lines to transfer.
REQ-006 ddr_st_addr  input  DDR_ADDR_LEN  DDR destination byte address.
REQ-007 ob_st_addr  input  ADDR_LEN  output-buffer start word address.
REQ-008 ddr_st_addr_out  output  DDR_ADDR_LEN  latched DDR address for the write engine.
REQ-009 ddr_len  output  SINGLE_LEN  transfer length in bytes.
REQ-010 ddr_conf  output  1  one-cycle pulse to the DDR write engine.
REQ-011 ob_addr  output  ADDR_LEN  output-buffer read address.
REQ-012 ob_en  output  1  output-buffer read enable.
REQ-013 ob_data  input  DATA_LEN*8  read data, all 8 banks concatenated, valid RD_LATENCY cycles after ob_en.
REQ-014 ddr_fifo_full  input  1  DDR write FIFO full.
REQ-015 ddr_fifo_wr  output  1  DDR write FIFO push strobe.
REQ-016 ddr_fifo_data  output  DATA_LEN*8  push data.
REQ-017 idle  output  1  high when no transfer is active.

Function
REQ-018 States SHALL be IDLE, ISSUE (reads outstanding) and DRAIN (all reads issued, lines still to push); from IDLE, conf with line_num>0 enters ISSUE; ISSUE enters DRAIN after the read of the last line; DRAIN enters IDLE after the push of the last line.
REQ-019 On conf in IDLE, the block SHALL register ddr_st_addr_out<=ddr_st_addr, ddr_len<=(line_num<<6) truncated to SINGLE_LEN, and pulse ddr_conf high for exactly the following cycle.
REQ-020 conf with line_num==0 SHALL produce no ddr_conf, no reads and no state change; conf outside IDLE SHALL be ignored.
REQ-021 The first ob_en SHALL come no earlier than the cycle after ddr_conf; ob_addr SHALL start at ob_st_addr and advance by 1 per issued read, wrapping modulo 2^ADDR_LEN.
REQ-022 Credit rule: reads in flight plus skid FIFO occupancy SHALL never exceed SKID_DEPTH, and ob_en SHALL be asserted only while that sum is below SKID_DEPTH and reads issued < line_num.
REQ-023 Each ob_data word returned RD_LATENCY cycles after ob_en SHALL be written to the skid FIFO unconditionally; the skid FIFO SHALL never overflow.
REQ-024 ddr_fifo_wr SHALL equal (skid FIFO not empty AND NOT ddr_fifo_full), combinationally; ddr_fifo_data SHALL be the skid head; a push and a skid write in the same cycle SHALL both complete.
REQ-025 Lines SHALL be pushed in address order with no loss or duplication; with ddr_fifo_full constantly low, throughput SHALL be one line per cycle after an initial latency of RD_LATENCY+1 cycles from the first ob_en.
REQ-026 Internal counters (issued, pushed) SHALL be SINGLE_LEN bits wide and compare against the latched line_num.
REQ-027 idle SHALL be low from the cycle after an accepted conf through the cycle of the last push, and high from the following cycle.

Reset
REQ-028 rst asserted at any time, including mid-transfer, SHALL asynchronously set state=IDLE, clear counters, empty the skid FIFO, discard in-flight reads, and drive ddr_conf=0, ob_en=0, ddr_fifo_wr=0, ob_addr=0, ddr_st_addr_out=0, ddr_len=0, ddr_fifo_data=0, idle=1.
REQ-029 Read data returning after reset release from reads issued before reset SHALL be ignored.

Verification
REQ-030 conf, line_num=4, ddr_st_addr=0x1000, ob_st_addr=0x10, full=0 -> single ddr_conf pulse, ddr_len=256, ob_addr 0x10..0x13, 4 pushes in order, idle high after the last push.
REQ-031 line_num=16, ddr_fifo_full high for 20 cycles mid-transfer -> ob_en stalls once occupancy reaches 4, no overflow, all 16 lines pushed in order.
REQ-032 ob_st_addr=0xFFFE, line_num=4 -> read addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-033 line_num=0 conf, then conf while busy -> no ddr_conf for either, and the active transfer is unaffected.
REQ-034 rst pulsed after 3 of 8 lines pushed -> all outputs at reset values, idle=1; a new conf with line_num=2 completes cleanly with exactly 2 pushes.
